// File: rtl/bram_seq_pkg.sv
// Shared types and constants for the BRAM sequential self-test master.
// Watchdog feature is compiled in by BRAM_SEQ_WATCHDOG_EN.
package bram_seq_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_FIN
    } state_e;

endpackage

// File: rtl/bram_seq_watchdog.sv
// Per-command response watchdog for bram_seq_master.
// Armed on each command pulse, disarmed on response; flags expiry.
module bram_seq_watchdog
    import bram_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          armed_q;

    assign expired_o = armed_q && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (load_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else if (clear_i) begin
            armed_q <= 1'b0;
        end else if (armed_q && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bram_seq_master.sv
// Built-in write/read-back self-test master for the BRAM controller command port.
// Define BRAM_SEQ_WATCHDOG_EN to compile in the per-command response watchdog.
module bram_seq_master
    import bram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ERR_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_num,
    input  logic [DATA_WIDTH-1:0] i_seed,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ERR_WIDTH-1:0]  o_err_cnt,
    output logic                  o_timeout,
    output logic                  o_run,
    output logic                  o_mode,
    output logic [ADDR_WIDTH-1:0] o_bramAddr,
    output logic [DATA_WIDTH-1:0] o_write_data,
    input  logic                  i_idle,
    input  logic                  i_done,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  i_read_valid
);

    state_e                state_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ERR_WIDTH-1:0]  err_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic                  timeout_q;
    logic                  run_q;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] baddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] pat_d;
    logic                  last_d;
    logic                  wd_expire;

    assign pat_d  = seed_q + DATA_WIDTH'(addr_q);
    // Compare in ADDR_WIDTH+1 bits so a full-depth run ends at the top word.
    assign last_d = ({1'b0, addr_q} == (num_q - 1'b1));

`ifdef BRAM_SEQ_WATCHDOG_EN
    bram_seq_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wd (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (run_q),
        .clear_i  (i_done | i_read_valid | ~busy_q),
        .expired_o(wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            seed_q    <= '0;
            addr_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            run_q     <= 1'b0;
            mode_q    <= 1'b0;
            baddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        num_q     <= i_num;
                        seed_q    <= i_seed;
                        addr_q    <= '0;
                        err_q     <= '0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= (i_num == '0) ? S_FIN : S_WR_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    if (i_idle) begin
                        run_q   <= 1'b1;
                        mode_q  <= MODE_WRITE;
                        baddr_q <= addr_q;
                        wdata_q <= pat_d;
                        state_q <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (i_done) begin
                        if (last_d) begin
                            addr_q  <= '0;
                            state_q <= S_RD_ISSUE;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= S_WR_ISSUE;
                        end
                    end else if (wd_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_FIN;
                    end
                end
                S_RD_ISSUE: begin
                    if (i_idle) begin
                        run_q   <= 1'b1;
                        mode_q  <= MODE_READ;
                        baddr_q <= addr_q;
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (i_read_valid) begin
                        if ((i_read_data != pat_d) && (err_q != '1)) begin
                            err_q <= err_q + 1'b1;
                        end
                        if (last_d) begin
                            state_q <= S_FIN;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= S_RD_ISSUE;
                        end
                    end else if (wd_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (err_q == '0) && !timeout_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_err_cnt    = err_q;
    assign o_timeout    = timeout_q;
    assign o_run        = run_q;
    assign o_mode       = mode_q;
    assign o_bramAddr   = baddr_q;
    assign o_write_data = wdata_q;

endmodule
